// File: rtl/row_feed.sv
// row_feed: per-line texture row stage; divides and multiplies a trace result serially
// into a step/start pair, then steps texv across the visible pixels of the next line.
module row_feed #(
    parameter int H_VIEW = 640
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trace_valid,
    output logic        trace_ready,
    input  logic        trace_side,
    input  logic [10:0] trace_size,
    input  logic [5:0]  trace_texu,
    input  logic        line_start,
    input  logic        visible,
    output logic        side,
    output logic [10:0] size,
    output logic [5:0]  texu,
    output logic [5:0]  texv,
    output logic        row_valid,
    output logic        underrun
);
    typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;
    localparam logic [17:0] HALF = 18'(H_VIEW / 2);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        p_side_q, p_side_d;
    logic [10:0] p_size_q, p_size_d;
    logic [5:0]  p_texu_q, p_texu_d;
    logic [10:0] rem_q, rem_d;
    logic [17:0] quo_q, quo_d;
    logic [17:0] mcand_q, mcand_d;
    logic [10:0] mplier_q, mplier_d;
    logic [17:0] prod_q, prod_d;
    logic [17:0] p_acc0_q, p_acc0_d;
    logic        side_q, side_d;
    logic [10:0] size_q, size_d;
    logic [5:0]  texu_q, texu_d;
    logic [17:0] step_q, step_d;
    logic [17:0] acc0_q, acc0_d;
    logic [17:0] acc_q, acc_d;
    logic        row_valid_q, row_valid_d;
    logic        underrun_q, underrun_d;
    logic [10:0] divisor;
    logic [11:0] rem_sh;
    logic        fits;

    always_comb begin
        divisor = (p_size_q == 11'd0) ? 11'd1 : p_size_q;
        // dividend is 2^17, so only the first quotient step shifts in a one
        rem_sh = {rem_q, cnt_q == 5'd0};
        fits = rem_sh >= {1'b0, divisor};
        state_d = state_q;
        cnt_d = cnt_q;
        p_side_d = p_side_q;
        p_size_d = p_size_q;
        p_texu_d = p_texu_q;
        rem_d = rem_q;
        quo_d = quo_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        prod_d = prod_q;
        p_acc0_d = p_acc0_q;
        side_d = side_q;
        size_d = size_q;
        texu_d = texu_q;
        step_d = step_q;
        acc0_d = acc0_q;
        acc_d = acc_q;
        row_valid_d = row_valid_q;
        case (state_q)
            IDLE: if (trace_valid) begin
                state_d = DIV;
                cnt_d = 5'd0;
                p_side_d = trace_side;
                p_size_d = trace_size;
                p_texu_d = trace_texu;
                rem_d = 11'd0;
                quo_d = 18'd0;
            end
            DIV: begin
                rem_d = fits ? 11'(rem_sh - {1'b0, divisor}) : rem_sh[10:0];
                quo_d = {quo_q[16:0], fits};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd17) begin
                    state_d = MUL;
                    cnt_d = 5'd0;
                    mcand_d = {quo_q[16:0], fits};
                    mplier_d = divisor;
                    prod_d = 18'd0;
                end
            end
            MUL: if (cnt_q == 5'd11) begin
                // size*step accumulated; remove the centre offset in one subtract
                p_acc0_d = prod_q - HALF * quo_q;
                state_d = DONE;
            end else begin
                prod_d = mplier_q[0] ? prod_q + mcand_q : prod_q;
                mcand_d = {mcand_q[16:0], 1'b0};
                mplier_d = mplier_q >> 1;
                cnt_d = cnt_q + 5'd1;
            end
            DONE: ;
        endcase
        underrun_d = line_start && state_q != DONE;
        if (line_start && state_q == DONE) begin
            state_d = IDLE;
            side_d = p_side_q;
            size_d = p_size_q;
            texu_d = p_texu_q;
            step_d = quo_q;
            acc0_d = p_acc0_q;
            acc_d = p_acc0_q;
            row_valid_d = 1'b1;
        end else if (line_start) begin
            acc_d = acc0_q;
            row_valid_d = 1'b0;
        end else if (visible) begin
            acc_d = acc_q + step_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            p_side_q <= 1'b0;
            p_size_q <= '0;
            p_texu_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            prod_q <= '0;
            p_acc0_q <= '0;
            side_q <= 1'b0;
            size_q <= '0;
            texu_q <= '0;
            step_q <= '0;
            acc0_q <= '0;
            acc_q <= '0;
            row_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            p_side_q <= p_side_d;
            p_size_q <= p_size_d;
            p_texu_q <= p_texu_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            prod_q <= prod_d;
            p_acc0_q <= p_acc0_d;
            side_q <= side_d;
            size_q <= size_d;
            texu_q <= texu_d;
            step_q <= step_d;
            acc0_q <= acc0_d;
            acc_q <= acc_d;
            row_valid_q <= row_valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign trace_ready = state_q == IDLE;
    assign side = side_q;
    assign size = size_q;
    assign texu = texu_q;
    assign texv = acc_q[17:12];
    assign row_valid = row_valid_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_row_feed.sv
// tb_row_feed: directed lines against a pixel-level model of the row feed,
// with hand-computed texv/flag values pinning the model.
module tb_row_feed;
    localparam int H_VIEW = 640;
    localparam int HALF = H_VIEW / 2;
    localparam int M18 = 262144;

    logic        clk = 0, reset_n = 0, trace_valid = 0, trace_side = 0;
    logic        line_start = 0, visible = 0;
    logic [10:0] trace_size = 0;
    logic [5:0]  trace_texu = 0;
    logic        trace_ready, side, row_valid, underrun;
    logic [10:0] size;
    logic [5:0]  texu, texv;

    row_feed #(.H_VIEW(H_VIEW)) dut (
        .clk(clk), .reset_n(reset_n), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_side(trace_side), .trace_size(trace_size), .trace_texu(trace_texu),
        .line_start(line_start), .visible(visible), .side(side), .size(size), .texu(texu),
        .texv(texv), .row_valid(row_valid), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int step_of(input int s);
        int e;
        e = (s == 0) ? 1 : s;
        return 131072 / e;
    endfunction

    function automatic int acc0_of(input int s);
        int e;
        e = (s == 0) ? 1 : s;
        return (((e - HALF) * step_of(s)) % M18 + M18) % M18;
    endfunction

    // model: pending row with an age since capture, active row, running accumulator
    int m_busy, m_age, m_done, m_idle, m_acc, m_rv, m_ur;
    int p_side, p_size, p_texu, p_step, p_acc0;
    int a_side, a_size, a_texu, a_step, a_acc0;
    int dut_hs = 0;
    logic rdy_s = 1;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_busy = 0; m_age = 0; m_acc = 0; m_rv = 0; m_ur = 0;
            p_side = 0; p_size = 0; p_texu = 0; p_step = 0; p_acc0 = 0;
            a_side = 0; a_size = 0; a_texu = 0; a_step = 0; a_acc0 = 0;
        end else begin
            if (trace_valid && rdy_s) dut_hs++;
            m_done = (m_busy != 0 && m_age >= 30) ? 1 : 0;
            m_idle = (m_busy == 0) ? 1 : 0;
            m_ur = 0;
            if (m_busy != 0) m_age++;
            if (line_start) begin
                if (m_done != 0) begin
                    a_side = p_side; a_size = p_size; a_texu = p_texu;
                    a_step = p_step; a_acc0 = p_acc0;
                    m_acc = p_acc0; m_rv = 1; m_busy = 0;
                end else begin
                    m_acc = a_acc0; m_rv = 0; m_ur = 1;
                end
            end else if (visible) begin
                m_acc = (m_acc + a_step) % M18;
            end
            if (m_idle != 0 && trace_valid) begin
                p_side = int'(trace_side); p_size = int'(trace_size); p_texu = int'(trace_texu);
                p_step = step_of(p_size); p_acc0 = acc0_of(p_size);
                m_busy = 1; m_age = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        rdy_s = trace_ready;
        if (reset_n) begin
            chk("trace_ready", int'(trace_ready), (m_busy == 0) ? 1 : 0);
            chk("row_valid", int'(row_valid), m_rv);
            chk("underrun", int'(underrun), m_ur);
            chk("side", int'(side), a_side);
            chk("size", int'(size), a_size);
            chk("texu", int'(texu), a_texu);
            chk("texv", int'(texv), m_acc / 4096);
        end
    end

    task automatic send(input int s, input int sd, input int tx);
        int n;
        n = 0;
        while (!trace_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(trace_ready), 1);
        trace_valid = 1; trace_size = 11'(s); trace_side = sd[0]; trace_texu = 6'(tx);
        @(negedge clk);
        trace_valid = 0;
    endtask

    task automatic run_line(input int h0, input int e0, input int h1, input int e1,
                            input int h2, input int e2);
        line_start = 1;
        @(negedge clk);
        line_start = 0;
        visible = 1;
        for (int k = 0; k < H_VIEW; k++) begin
            if (k == h0) chk("texv_lit_a", int'(texv), e0);
            if (k == h1) chk("texv_lit_b", int'(texv), e1);
            if (k == h2) chk("texv_lit_c", int'(texv), e2);
            @(negedge clk);
        end
        visible = 0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hs0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(trace_ready), 1);
        chk("rst_row_valid", int'(row_valid), 0);
        chk("rst_texv", int'(texv), 0);
        chk("rst_size", int'(size), 0);
        chk("rst_underrun", int'(underrun), 0);
        reset_n = 1;
        @(negedge clk);
        // size 32: step 4096, acc0 131072
        send(32, 1, 5);
        repeat (31) @(negedge clk);
        run_line(288, 0, 289, 1, 351, 63);
        chk("rv_32", int'(row_valid), 1);
        chk("size_32", int'(size), 32);
        // size 320: step 409, acc0 0
        send(320, 0, 9);
        repeat (31) @(negedge clk);
        run_line(0, 0, 639, 63, -1, 0);
        chk("rv_320", int'(row_valid), 1);
        chk("texu_320", int'(texu), 9);
        // size 2047: step 64, acc0 110528
        send(2047, 1, 63);
        repeat (31) @(negedge clk);
        run_line(0, 26, 1, 27, -1, 0);
        chk("size_2047", int'(size), 2047);
        // size 1: step 131072, texv alternates 32/0
        send(1, 0, 1);
        repeat (31) @(negedge clk);
        run_line(0, 32, 1, 0, 2, 32);
        // line_start 10 cycles after handshake: underrun, old row held
        send(100, 1, 7);
        repeat (9) @(negedge clk);
        line_start = 1;
        @(negedge clk);
        line_start = 0;
        chk("ur_pulse", int'(underrun), 1);
        chk("ur_row_valid", int'(row_valid), 0);
        chk("ur_size_held", int'(size), 1);
        chk("ur_texu_held", int'(texu), 1);
        @(negedge clk);
        chk("ur_one_cycle", int'(underrun), 0);
        repeat (40) @(negedge clk);
        run_line(0, 57, 2, 58, -1, 0);
        chk("rv_100", int'(row_valid), 1);
        chk("size_100", int'(size), 100);
        // trace_valid held high: one capture per line
        hs0 = dut_hs;
        trace_valid = 1; trace_size = 11'd64; trace_side = 0; trace_texu = 6'd3;
        repeat (40) @(negedge clk);
        run_line(0, 0, 2, 1, -1, 0);
        run_line(-1, 0, -1, 0, -1, 0);
        trace_valid = 0;
        chk("captures", dut_hs - hs0, 3);
        line_start = 1;
        @(negedge clk);
        line_start = 0;
        // reset in the middle of the divide
        send(50, 1, 2);
        repeat (5) @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("arst_ready", int'(trace_ready), 1);
        chk("arst_row_valid", int'(row_valid), 0);
        chk("arst_side", int'(side), 0);
        chk("arst_size", int'(size), 0);
        chk("arst_texu", int'(texu), 0);
        chk("arst_texv", int'(texv), 0);
        chk("arst_underrun", int'(underrun), 0);
        @(negedge clk);
        reset_n = 1;
        trace_valid = 1; trace_size = 11'd33; trace_side = 1; trace_texu = 6'd11;
        chk("rel_ready", int'(trace_ready), 1);
        @(negedge clk);
        trace_valid = 0;
        chk("rel_captured", int'(trace_ready), 0);
        repeat (31) @(negedge clk);
        run_line(0, 41, -1, 0, -1, 0);
        chk("size_33", int'(size), 33);
        // size 0 divides as 1 but reports 0
        send(0, 0, 4);
        repeat (31) @(negedge clk);
        run_line(0, 32, 1, 0, -1, 0);
        chk("size_0", int'(size), 0);
        chk("rv_0", int'(row_valid), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
